// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   localparam int STAT_W = 16;
   localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == STAT_MAX) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr,
// wrapping modulo NUM_REQ (works for non-power-of-2 NUM_REQ).
module rr_priority_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any
);

   always_comb begin
      int idx;
      logic [ID_W-1:0] idx_l;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = 0;
      idx_l     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_l = ID_W'(idx);
         if (!any && req[idx_l]) begin
            any          = 1'b1;
            grant[idx_l] = 1'b1;
            grant_idx    = idx_l;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter feeding the asynchronous FIFO write side.
// Optional statistics counters are enabled with `define FIFO_ARB_STATS_EN.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int BITSIZE   = 8,
   parameter int NUM_REQ   = 4,
   parameter int BURST_LEN = 4,
   parameter int ID_W      = $clog2(NUM_REQ)
) (
   input  logic                       w_clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*BITSIZE-1:0] req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       full,
   output logic                       w_enable,
   output logic [BITSIZE-1:0]         wdata,
   output logic [ID_W-1:0]            wsrc
`ifdef FIFO_ARB_STATS_EN
   ,
   input  logic [ID_W-1:0]            stat_sel,
   output logic [STAT_W-1:0]          stat_grants,
   output logic [STAT_W-1:0]          stat_stalls
`endif
);

   localparam int CNT_W = $clog2(BURST_LEN + 1);
   localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

   arb_state_t          state_q, state_d;
   logic [ID_W-1:0]     owner_q, owner_d;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic                out_valid_q, out_valid_d;
   logic [BITSIZE-1:0]  out_data_q, out_data_d;
   logic [ID_W-1:0]     out_src_q, out_src_d;

   logic [NUM_REQ-1:0]  pick_grant;
   logic [ID_W-1:0]     pick_idx;
   logic                pick_any;
   logic                can_load;
   logic                xfer;
   logic [ID_W-1:0]     xfer_idx;
   logic [BITSIZE-1:0]  sel_data;
   logic [CNT_W-1:0]    beat_inc;

   rr_priority_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req       (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .any       (pick_any)
   );

   assign w_enable = out_valid_q & ~full;
   assign can_load = ~out_valid_q | w_enable;
   assign wdata    = out_data_q;
   assign wsrc     = out_src_q;
   assign beat_inc = beat_cnt_q + CNT_W'(1);

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (xfer_idx == ID_W'(i)) sel_data = req_data[i*BITSIZE +: BITSIZE];
      end
   end

   // Grants are suppressed while reset is held so no word is consumed and then lost.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      req_ready  = '0;
      xfer       = 1'b0;
      xfer_idx   = owner_q;
      if (reset && can_load) begin
         case (state_q)
            ARB_IDLE: begin
               if (pick_any) begin
                  req_ready  = pick_grant;
                  xfer       = 1'b1;
                  xfer_idx   = pick_idx;
                  owner_d    = pick_idx;
                  beat_cnt_d = CNT_W'(1);
                  rr_ptr_d   = (pick_idx == LAST_ID) ? '0 : pick_idx + ID_W'(1);
                  state_d    = (BURST_LEN > 1) ? ARB_BURST : ARB_IDLE;
               end
            end
            ARB_BURST: begin
               if (req_valid[owner_q]) begin
                  req_ready[owner_q] = 1'b1;
                  xfer               = 1'b1;
                  beat_cnt_d         = beat_inc;
                  if (beat_inc == BURST_MAX) state_d = ARB_IDLE;
               end else begin
                  state_d = ARB_IDLE;
               end
            end
            default: state_d = ARB_IDLE;
         endcase
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (can_load) begin
         out_valid_d = xfer;
         if (xfer) begin
            out_data_d = sel_data;
            out_src_d  = xfer_idx;
         end
      end
   end

   always_ff @(posedge w_clk) begin
      if (!reset) begin
         state_q     <= ARB_IDLE;
         owner_q     <= '0;
         beat_cnt_q  <= '0;
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         beat_cnt_q  <= beat_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [STAT_W-1:0] grant_cnt_q [NUM_REQ];
   logic [STAT_W-1:0] grant_cnt_d [NUM_REQ];
   logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      grant_cnt_d = grant_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (xfer) grant_cnt_d[xfer_idx] = sat_inc(grant_cnt_q[xfer_idx]);
      if (out_valid_q && full) stall_cnt_d = sat_inc(stall_cnt_q);
   end

   always_comb begin
      stat_grants = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (stat_sel == ID_W'(i)) stat_grants = grant_cnt_q[i];
      end
   end

   assign stat_stalls = stall_cnt_q;

   always_ff @(posedge w_clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
         stall_cnt_q <= '0;
      end else begin
         grant_cnt_q <= grant_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench: two arbiter instances (BURST_LEN 4 and 1) share one set of producers.
module tb_fifo_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        full;
   logic [3:0]  rv;
   logic [31:0] rd;
   logic [3:0]  rdy_a, rdy_b;
   logic        we_a, we_b;
   logic [7:0]  wd_a, wd_b;
   logic [1:0]  ws_a, ws_b;
`ifdef FIFO_ARB_STATS_EN
   logic [1:0]  stat_sel;
   logic [15:0] sg_a, ss_a, sg_b, ss_b;
`endif

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   bit          sel_b = 1'b0;
   int          cnt [4];
   logic [7:0]  nd  [4];
   logic        fired [4];
   logic [9:0]  exp_q [$];
   int          wcyc  [$];

   always #5 clk = ~clk;

   fifo_write_arbiter #(.BITSIZE(8), .NUM_REQ(4), .BURST_LEN(4)) dut_a (
      .w_clk(clk), .reset(reset), .req_valid(rv), .req_data(rd), .req_ready(rdy_a),
      .full(full), .w_enable(we_a), .wdata(wd_a), .wsrc(ws_a)
`ifdef FIFO_ARB_STATS_EN
      , .stat_sel(stat_sel), .stat_grants(sg_a), .stat_stalls(ss_a)
`endif
   );

   fifo_write_arbiter #(.BITSIZE(8), .NUM_REQ(4), .BURST_LEN(1)) dut_b (
      .w_clk(clk), .reset(reset), .req_valid(rv), .req_data(rd), .req_ready(rdy_b),
      .full(full), .w_enable(we_b), .wdata(wd_b), .wsrc(ws_b)
`ifdef FIFO_ARB_STATS_EN
      , .stat_sel(stat_sel), .stat_grants(sg_b), .stat_stalls(ss_b)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic logic       cur_we();  return sel_b ? we_b  : we_a;  endfunction
   function automatic logic [7:0] cur_wd();  return sel_b ? wd_b  : wd_a;  endfunction
   function automatic logic [3:0] cur_rdy(); return sel_b ? rdy_b : rdy_a; endfunction

   // Called at a negedge; returns at the following negedge after one rising edge.
   task automatic tick();
      logic [9:0] e;
      #3;
      for (int i = 0; i < 4; i++) fired[i] = rv[i] & cur_rdy()[i];
      if (cur_we()) begin
         wcyc.push_back(cyc);
         if (exp_q.size() == 0) chk("extra_wr", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("wr", sel_b ? {ws_b, wd_b} : {ws_a, wd_a}, e);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (fired[i]) begin
            cnt[i]--;
            nd[i] = nd[i] + 8'd1;
         end
         rv[i]          = (cnt[i] > 0);
         rd[i*8 +: 8]   = nd[i];
      end
      @(negedge clk);
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
         tick();
         done = (exp_q.size() == 0) && (cnt[0] == 0) && (cnt[1] == 0) &&
                (cnt[2] == 0) && (cnt[3] == 0);
      end
      chk("drain", done, 1);
      tick();
      tick();
   endtask

   task automatic stall_test(input int r, input logic [7:0] d0);
      bit seen = 1'b0;
      wcyc.delete();
      cnt[r] = 2;
      nd[r]  = d0;
      full   = 1'b1;
      exp_q.push_back({2'(r), d0});
      exp_q.push_back({2'(r), d0 + 8'd1});
      for (int n = 0; n < 10 && !seen; n++) begin
         tick();
         seen = (cur_wd() == d0);
      end
      chk("stall_seen", seen, 1);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) tick();
         chk("stall_we", cur_we(), 0);
         chk("stall_wd", cur_wd(), d0);
         chk("stall_rdy", cur_rdy(), 0);
      end
      tick();
      full = 1'b0;
      drain();
      chk("stall_nwr", wcyc.size(), 2);
      if (wcyc.size() == 2) chk("stall_gap", wcyc[1] - wcyc[0], 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      full  = 1'b0;
      rv    = 4'hF;
      rd    = 32'h04030201;
`ifdef FIFO_ARB_STATS_EN
      stat_sel = 2'd1;
`endif
      for (int i = 0; i < 4; i++) begin
         cnt[i] = 1;
         nd[i]  = 8'(i + 1);
         fired[i] = 1'b0;
         exp_q.push_back({2'(i), 8'(i + 1)});
      end

      // Reset held two cycles with every producer valid.
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         if (k > 0) tick();
         chk("rst_we", we_a, 0);
         chk("rst_rdy", rdy_a, 0);
         chk("rst_wd", wd_a, 0);
         chk("rst_ws", ws_a, 0);
         chk("rst_rdy_b", rdy_b, 0);
      end
      reset = 1'b1;
      #1;
      chk("first_grant", rdy_a, 4'b0001);
      drain();

      // Single producer streams without bubbles.
      wcyc.delete();
      cnt[2] = 3;
      nd[2]  = 8'hA5;
      for (int k = 0; k < 3; k++) exp_q.push_back({2'd2, 8'hA5 + 8'(k)});
      drain();
      chk("single_nwr", wcyc.size(), 3);
      if (wcyc.size() == 3) chk("single_gap", wcyc[2] - wcyc[0], 2);

      // Two producers under burst lock of 4.
      wcyc.delete();
      cnt[0] = 5; nd[0] = 8'h10;
      cnt[1] = 4; nd[1] = 8'h20;
      for (int k = 0; k < 4; k++) exp_q.push_back({2'd0, 8'h10 + 8'(k)});
      for (int k = 0; k < 4; k++) exp_q.push_back({2'd1, 8'h20 + 8'(k)});
      exp_q.push_back({2'd0, 8'h14});
      drain();
      chk("burst_nwr", wcyc.size(), 9);
      if (wcyc.size() == 9) chk("burst_gap", wcyc[8] - wcyc[0], 8);

      // Owner drops valid after two beats: one bubble, then req0.
      wcyc.delete();
      cnt[1] = 2; nd[1] = 8'h30;
      cnt[0] = 1; nd[0] = 8'h40;
      exp_q.push_back({2'd1, 8'h30});
      exp_q.push_back({2'd1, 8'h31});
      exp_q.push_back({2'd0, 8'h40});
      drain();
      chk("drop_nwr", wcyc.size(), 3);
      if (wcyc.size() == 3) chk("drop_bubble", wcyc[2] - wcyc[1], 2);

      stall_test(3, 8'h3C);

      // Switch to the BURST_LEN=1 instance; reset mid-stream with producers loaded.
      sel_b = 1'b1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cnt[i] = 2;
         nd[i]  = 8'h60 + 8'(16 * i);
      end
      tick();
      tick();
      chk("rst2_we", we_b, 0);
      chk("rst2_rdy", rdy_b, 0);
`ifdef FIFO_ARB_STATS_EN
      chk("rst_stat_grants", sg_b, 0);
      chk("rst_stat_stalls", ss_b, 0);
`endif
      wcyc.delete();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), 8'h60 + 8'(16 * i) + 8'(k)});
      reset = 1'b1;
      drain();
      chk("rr_nwr", wcyc.size(), 8);
      if (wcyc.size() == 8) chk("rr_gap", wcyc[7] - wcyc[0], 7);

      stall_test(2, 8'hC3);
`ifdef FIFO_ARB_STATS_EN
      stat_sel = 2'd1;
      #1;
      chk("stat_grants1", sg_b, 2);
      chk("stat_stalls", ss_b, 3);
      stat_sel = 2'd2;
      #1;
      chk("stat_grants2", sg_b, 4);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-port arbiter that shares the `asynchronous_fifo` write side between `NUM_REQ` producers in the `w_clk` domain. Each producer uses a valid/ready handshake. The arbiter serialises the winners into a one-entry output register and drives the FIFO's `w_enable`/`wdata`, gated by the FIFO's `full` flag so the FIFO never overflows. An optional burst lock keeps one producer granted for up to `BURST_LEN` consecutive words.

## Interface
- `BITSIZE`, 8: data word width; matches the FIFO `BITSIZE`.
- `NUM_REQ`, 4: number of requesters, 2..16.
- `BURST_LEN`, 4: maximum consecutive words per grant, ≥1.
- `ID_W`, `$clog2(NUM_REQ)`: requester index width.

Ports:
- `w_clk`  in  1  write-domain clock; the only clock.
- `reset`  in  1  synchronous, active-low reset; `reset`=0 resets on the next `w_clk` rising edge.
- `req_valid`  in  NUM_REQ  per-requester word valid.
- `req_data`  in  NUM_REQ*BITSIZE  requester i occupies `[i*BITSIZE +: BITSIZE]`.
- `req_ready`  out  NUM_REQ  one-hot (or zero) accept strobe.
- `full`  in  1  FIFO full flag, `w_clk` domain.
- `w_enable`  out  1  FIFO write enable.
- `wdata`  out  BITSIZE  FIFO write data.
- `wsrc`  out  ID_W  index of the requester owning `wdata`.

## Operation
- Output stage registers: `out_valid`, `out_data`, `out_src`.
- `w_enable = out_valid & ~full`, combinational. `wdata = out_data`. `wsrc = out_src`.
- `can_load = ~out_valid | w_enable`.
- A transfer from requester i occurs when `req_valid[i] & req_ready[i]`. The output stage loads `req_data[i]` and sets `out_src = i`.
- If `can_load` holds and nothing transfers, `out_valid` is cleared.
- Requester rules:
  - A requester holds `req_valid` and its data stable until `req_ready` is asserted.
  - `req_valid` must not depend on `req_ready`.
  - `req_ready` may depend on `req_valid`.
- State machine (`arb_state_t`), with registers `owner`, `beat_cnt`, `rr_ptr`:
  - ARB_IDLE:
    - If `can_load` and any `req_valid`, grant g = the first valid index at or after `rr_ptr`, wrapping modulo NUM_REQ (non-power-of-2 NUM_REQ handled).
    - `req_ready[g]=1`; `owner<=g`; `beat_cnt<=1`; `rr_ptr<=(g+1) mod NUM_REQ`.
    - Go to ARB_BURST if BURST_LEN>1, else stay in ARB_IDLE.
  - ARB_BURST:
    - `req_ready[owner] = can_load & req_valid[owner]`; all others are 0.
    - On a transfer, `beat_cnt++`. Return to ARB_IDLE when `beat_cnt` reaches BURST_LEN.
    - If `can_load & ~req_valid[owner]`, return to ARB_IDLE with no transfer; this costs one bubble cycle.
- While `full`=1 with `out_valid`=1: `can_load`=0, all `req_ready`=0, the output stage holds, and the state is frozen.
- Reset values:
  - `out_valid`=0, so `w_enable`=0.
  - `wdata`=0, `wsrc`=0, `req_ready`=0.
  - ARB_IDLE, `rr_ptr`=0, `beat_cnt`=0, `owner`=0, stat counters 0.
- Reset mid-operation discards any pending output word and any open burst. Requesters re-present their words after reset.

## Timing
- A word accepted at edge k is on `wdata` with `w_enable`=1 during cycle k+1, provided `full`=0. The FIFO writes it at edge k+1.
- Throughput is one word per cycle while `full`=0.
- A `full` rise drops `w_enable` in the same cycle, combinationally. No word is lost or duplicated.
- If `full` falls during cycle j, the held word is written at edge j+1 and a new grant may occur in the same cycle j.
- Worst-case wait for requester i is (NUM_REQ-1)*BURST_LEN transfers plus full-stall cycles.

## Configuration
- `FIFO_ARB_STATS_EN` defined adds three ports:
  - `stat_sel` in ID_W.
  - `stat_grants` out 16: per-requester count of transfers, saturating at 16'hFFFF, selected combinationally by `stat_sel`.
  - `stat_stalls` out 16: saturating count of cycles with `out_valid & full`.
  - All counters clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- `fifo_arb_pkg` contains:
  - `arb_state_t` (ARB_IDLE, ARB_BURST).
  - `STAT_W=16`.
  - The `STAT_MAX` constant.
- Sub-module `rr_priority_pick`: combinational. Inputs are the `req` vector and `rr_ptr`. Outputs are a one-hot grant plus `grant_idx` and `any`. It is parameterised by NUM_REQ.

## Test plan
- Reset: `reset`=0 for 2 cycles with `req_valid`=4'b1111 -> `w_enable`=0, `req_ready`=0, `wdata`=0, `wsrc`=0 throughout. First grant goes to req0 on the edge after release.
- Single producer: req2 streams 8'hA5, A6, A7 and `full`=0 -> `wdata` A5, A6, A7 on consecutive cycles, `wsrc`=2, no bubbles.
- BURST_LEN=1, all four `req_valid` held -> `wsrc` sequence 0,1,2,3,0,1, one write per cycle.
- BURST_LEN=4, req0 and req1 held -> `wsrc` 0,0,0,0,1,1,1,1,0. Dropping req1 valid after 2 beats -> one bubble, then `wsrc`=0.
- Output holds 8'h3C and `full`=1 for 3 cycles -> `w_enable`=0, `wdata`=8'h3C, `req_ready`=0. After `full` falls, exactly one write of 8'h3C occurs, and the next word follows on the next cycle.
- `FIFO_ARB_STATS_EN` with BURST_LEN=1 and 8 writes from 4 requesters plus a 3-cycle full stall -> `stat_grants`(sel=1)=2, `stat_stalls`=3. Both read 0 after reset.
